// File: rtl/uart_sdram_pkg.sv
// rtl/uart_sdram_pkg.sv - shared FSM encodings, header defaults and FIFO sizing for the UART command front end
package uart_sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_WR_TRIG = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

    localparam logic [7:0] HDR_WR_DEF = 8'h55;
    localparam logic [7:0] HDR_RD_DEF = 8'hAA;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/uart_sdram_byte_fifo.sv
// rtl/uart_sdram_byte_fifo.sv - first-word-fall-through byte FIFO with frame mark/rollback (rollback used under CMD_TIMEOUT_EN)
module uart_sdram_byte_fifo
    import uart_sdram_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    input  logic             mark,
    input  logic             rollback,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] count
);

    localparam int DEPTH = fifo_depth(FIFO_AW);
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE = 1;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] mark_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [FIFO_AW-1:0] frame_len;
    logic               do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign do_pop    = pop && !empty;
    // A push into a full FIFO still lands when the same cycle frees a slot
    assign do_push   = push && (!full || do_pop) && !rollback;
    assign frame_len = wr_ptr_q - mark_ptr_q;
    assign dout      = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rollback) begin
            wr_ptr_d = mark_ptr_q;
            count_d  = count_q - {1'b0, frame_len};
        end else if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_d - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mark_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (mark) begin
                mark_ptr_q <= wr_ptr_q;
            end
        end
    end

endmodule

// File: rtl/uart_sdram_cmd.sv
// rtl/uart_sdram_cmd.sv - UART byte parser producing SDRAM write frames/read requests; CMD_TIMEOUT_EN adds write-frame timeout
module uart_sdram_cmd
    import uart_sdram_pkg::*;
#(
    parameter int         WR_LEN      = 8,
    parameter int         RD_LEN      = 8,
    parameter int         FIFO_AW     = 4,
    parameter logic [7:0] HDR_WR      = HDR_WR_DEF,
    parameter logic [7:0] HDR_RD      = HDR_RD_DEF,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_trig,
    output logic       rd_trig,
    input  logic       wfifo_rd_en,
    output logic [7:0] wfifo_rd_data,
    input  logic       rfifo_wr_en,
    input  logic [7:0] rfifo_wr_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       ovf_err
);

    localparam int DEPTH = fifo_depth(FIFO_AW);
    localparam int CNT_W = $clog2(WR_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WR_LEN - 1);
    localparam logic [FIFO_AW:0]  RD_FILL_MAX = (FIFO_AW+1)'(DEPTH - RD_LEN);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_trig_q, rd_trig_q, ovf_q;

    logic             idle_like, start_wr, start_rd;
    logic             wfifo_push, wfifo_pop, wfifo_full, wfifo_empty;
    logic             wfifo_mark, wfifo_rollback, tmo_fire;
    logic [FIFO_AW:0] wfifo_count;
    logic             rfifo_pop, rfifo_full, rfifo_empty;
    logic [FIFO_AW:0] rfifo_count;
    logic             rd_room_ok, ovf_set;
    logic             unused_bits;

    // WR_TRIG lasts one cycle and accepts a new command as though idle
    assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_WR_TRIG);
    assign start_wr   = idle_like && rx_valid && (rx_data == HDR_WR);
    assign start_rd   = idle_like && rx_valid && (rx_data == HDR_RD);
    assign wfifo_push = (state_q == ST_WR_DATA) && rx_valid && !tmo_fire;
    assign wfifo_pop  = wfifo_rd_en && !wfifo_empty;
    assign rfifo_pop  = tx_valid && tx_ready;
    assign rd_room_ok = (rfifo_count <= RD_FILL_MAX);
    assign ovf_set    = (wfifo_push && wfifo_full && !wfifo_pop) ||
                        (rfifo_wr_en && rfifo_full && !rfifo_pop);

    assign wr_trig  = wr_trig_q;
    assign rd_trig  = rd_trig_q;
    assign ovf_err  = ovf_q;
    assign tx_valid = !rfifo_empty;
    assign unused_bits = ^wfifo_count;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q;

    assign tmo_fire       = (state_q == ST_WR_DATA) && !rx_valid && (tmo_q == TMO_LAST);
    assign wfifo_mark     = start_wr;
    assign wfifo_rollback = tmo_fire;

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            tmo_q <= '0;
        end else if ((state_q != ST_WR_DATA) || rx_valid) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_ONE;
        end
    end
`else
    logic unused_tmo;

    assign tmo_fire       = 1'b0;
    assign wfifo_mark     = 1'b0;
    assign wfifo_rollback = 1'b0;
    assign unused_tmo     = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_trig_q <= 1'b0;
            rd_trig_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_trig_q <= 1'b0;
            rd_trig_q <= 1'b0;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_WR_TRIG: begin
                    state_q <= ST_IDLE;
                    if (start_wr) begin
                        state_q <= ST_WR_DATA;
                        cnt_q   <= '0;
                    end else if (start_rd) begin
                        state_q   <= ST_RD_WAIT;
                        rd_trig_q <= rd_room_ok;
                    end
                end
                ST_WR_DATA: begin
                    if (tmo_fire) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_q   <= ST_WR_TRIG;
                            wr_trig_q <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // rd_trig is raised while still in RD_WAIT, then we leave
                    if (rd_trig_q) begin
                        state_q <= ST_IDLE;
                    end else if (rd_room_ok) begin
                        rd_trig_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_sdram_byte_fifo #(.FIFO_AW(FIFO_AW)) u_wfifo (
        .clk      (sclk),
        .rst      (s_rst),
        .push     (wfifo_push),
        .din      (rx_data),
        .pop      (wfifo_pop),
        .mark     (wfifo_mark),
        .rollback (wfifo_rollback),
        .dout     (wfifo_rd_data),
        .full     (wfifo_full),
        .empty    (wfifo_empty),
        .count    (wfifo_count)
    );

    uart_sdram_byte_fifo #(.FIFO_AW(FIFO_AW)) u_rfifo (
        .clk      (sclk),
        .rst      (s_rst),
        .push     (rfifo_wr_en),
        .din      (rfifo_wr_data),
        .pop      (rfifo_pop),
        .mark     (1'b0),
        .rollback (1'b0),
        .dout     (tx_data),
        .full     (rfifo_full),
        .empty    (rfifo_empty),
        .count    (rfifo_count)
    );

endmodule

// File: tb/tb_uart_sdram_cmd.sv
// tb/tb_uart_sdram_cmd.sv - directed self-checking bench for uart_sdram_cmd (timeout case only with CMD_TIMEOUT_EN)
module tb_uart_sdram_cmd;

    logic       sclk = 1'b0;
    logic       s_rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_trig, rd_trig;
    logic       wfifo_rd_en;
    logic [7:0] wfifo_rd_data;
    logic       rfifo_wr_en;
    logic [7:0] rfifo_wr_data;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, ovf_err;

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    int n_rd  = 0;
    int snap_wr, snap_rd;

    uart_sdram_cmd #(.TIMEOUT_CYC(100)) dut (
        .sclk          (sclk),
        .s_rst         (s_rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .wr_trig       (wr_trig),
        .rd_trig       (rd_trig),
        .wfifo_rd_en   (wfifo_rd_en),
        .wfifo_rd_data (wfifo_rd_data),
        .rfifo_wr_en   (rfifo_wr_en),
        .rfifo_wr_data (rfifo_wr_data),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .ovf_err       (ovf_err)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (wr_trig) n_wr++;
        if (rd_trig) n_rd++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rpush(input logic [7:0] b);
        rfifo_wr_data = b;
        rfifo_wr_en   = 1'b1;
        tick();
        rfifo_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        tick();
        tick();
        s_rst = 1'b0;
        tick();
    endtask

    logic [7:0] pl [8];

    initial begin
        s_rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; wfifo_rd_en = 1'b0;
        rfifo_wr_en = 1'b0; rfifo_wr_data = 8'h00; tx_ready = 1'b0;
        tick();
        check("rst_wr_trig", wr_trig, 0);
        check("rst_rd_trig", rd_trig, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_wdata", wfifo_rd_data, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        s_rst = 1'b0;
        tick();

        // write frame 55,01..08
        send(8'h55);
        for (int i = 1; i <= 7; i++) send(8'(i));
        check("t1_no_trig_early", wr_trig, 0);
        send(8'h08);
        check("t1_wr_trig", wr_trig, 1);
        wfifo_rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t1_wdata", wfifo_rd_data, 32'(i + 1));
            if (i == 0) check("t1_trig_one_cycle", wr_trig, 1);
            tick();
            if (i == 0) check("t1_trig_low", wr_trig, 0);
        end
        wfifo_rd_en = 1'b0;
        check("t1_wfifo_empty", wfifo_rd_data, 8'h00);

        // read request with empty read FIFO
        send(8'hAA);
        check("t2_rd_trig", rd_trig, 1);
        tick();
        check("t2_rd_trig_low", rd_trig, 0);
        for (int i = 0; i < 8; i++) rpush(8'hC0 + 8'(i));
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_tx_valid", tx_valid, 1);
            check("t2_tx_data", tx_data, 32'(8'hC0 + i));
            tick();
        end
        tx_ready = 1'b0;
        check("t2_tx_empty", tx_valid, 0);

        // read back-pressure: 10 bytes held, space only 6
        for (int i = 0; i < 10; i++) rpush(8'hD0 + 8'(i));
        send(8'hAA);
        check("t3_no_rd_trig", rd_trig, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_still_wait", rd_trig, 0);
        end
        tx_ready = 1'b1;
        tick();
        check("t3_after_pop1", rd_trig, 0);
        tick();
        tx_ready = 1'b0;
        check("t3_space_reached", rd_trig, 0);
        tick();
        check("t3_rd_trig", rd_trig, 1);
        tick();
        check("t3_rd_trig_low", rd_trig, 0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_tx_data", tx_data, 32'(8'hD2 + i));
            tick();
        end
        tx_ready = 1'b0;
        check("t3_tx_empty", tx_valid, 0);

        // overflow: two full frames fit, third is dropped
        send(8'h55);
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        check("t4_trig_f1", wr_trig, 1);
        send(8'h55);
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        check("t4_trig_f2", wr_trig, 1);
        check("t4_no_ovf", ovf_err, 0);
        send(8'h55);
        send(8'h30);
        check("t4_ovf_set", ovf_err, 1);
        for (int i = 1; i < 8; i++) send(8'h30 + 8'(i));
        check("t4_trig_f3", wr_trig, 1);
        wfifo_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t4_wdata", wfifo_rd_data, (i < 8) ? 32'(8'h10 + i) : 32'(8'h20 + i - 8));
            tick();
        end
        wfifo_rd_en = 1'b0;
        check("t4_wfifo_empty", wfifo_rd_data, 8'h00);
        check("t4_ovf_sticky", ovf_err, 1);

        // noise and header bytes as payload
        do_reset();
        check("t5_ovf_cleared", ovf_err, 0);
        snap_wr = n_wr; snap_rd = n_rd;
        send(8'h00); send(8'hAB); send(8'hFF);
        tick();
        check("t5_noise_no_wr", n_wr, snap_wr);
        check("t5_noise_no_rd", n_rd, snap_rd);
        check("t5_noise_wempty", wfifo_rd_data, 8'h00);
        check("t5_noise_tx", tx_valid, 0);
        pl = '{8'hA1, 8'hA2, 8'hA3, 8'hAA, 8'h55, 8'hA6, 8'hA7, 8'hA8};
        send(8'h55);
        for (int i = 0; i < 8; i++) send(pl[i]);
        check("t5_wr_trig", wr_trig, 1);
        tick();
        check("t5_no_rd_trig", n_rd, snap_rd);
        wfifo_rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t5_wdata", wfifo_rd_data, pl[i]);
            tick();
        end
        wfifo_rd_en = 1'b0;

        // reset mid-frame
        snap_wr = n_wr;
        send(8'h55); send(8'h01); send(8'h02);
        do_reset();
        check("t7_rst_wempty", wfifo_rd_data, 8'h00);
        send(8'h55);
        for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i));
        check("t7_head_fresh", wfifo_rd_data, 8'hE0);
        tick();
        check("t7_one_trig", n_wr, snap_wr + 1);

`ifdef CMD_TIMEOUT_EN
        // write-frame timeout rolls back partial payload
        do_reset();
        snap_wr = n_wr; snap_rd = n_rd;
        send(8'h55); send(8'h01); send(8'h02);
        for (int i = 0; i < 99; i++) tick();
        check("t6_before_tmo", wfifo_rd_data, 8'h01);
        tick();
        check("t6_rolled_back", wfifo_rd_data, 8'h00);
        check("t6_no_wr_trig", n_wr, snap_wr);
        send(8'hAA);
        check("t6_idle_rd_trig", rd_trig, 1);
        tick();
        send(8'h55);
        for (int i = 0; i < 8; i++) send(8'hB0 + 8'(i));
        check("t6_new_frame_trig", wr_trig, 1);
        check("t6_new_head", wfifo_rd_data, 8'hB0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
